fs_vector_checker: RTL and testbench

FS_VECTOR_CHECKER -- requirements
Module: fs_vector_checker

---
 rtl/fs_check_pkg.sv | 20 ++
 rtl/fs_golden_model.sv | 23 ++
 rtl/fs_vector_checker.sv | 130 +++++++++++++
 tb/tb_fs_vector_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fs_check_pkg.sv
// Shared types and widths for the full-subtractor/full-adder vector checker.
package fs_check_pkg;

   localparam int unsigned ERR_W = 4;
   localparam int unsigned VEC_W = 3;
   localparam int unsigned CNT_W = 4;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(7);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/fs_golden_model.sv
// Reference result for one vector: full subtractor (borrow) or full adder (carry).
module fs_golden_model
   import fs_check_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   input  logic mode,
   output logic exp_diff,
   output logic exp_bout
);

   // Difference and sum share the same parity; only the outgoing bit differs.
   always_comb begin
      exp_diff = a ^ b ^ bin;
      if (mode == MODE_ADD) begin
         exp_bout = (a & b) | (bin & (a ^ b));
      end else begin
         exp_bout = (~a & b) | (~(a ^ b) & bin);
      end
   end

endmodule

// File: rtl/fs_vector_checker.sv
// Walks all eight {a,b,bin} vectors, lets each settle, and scores the device result.
module fs_vector_checker
   import fs_check_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned MODE          = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a,
   output logic             b,
   output logic             bin,
   input  logic             diff,
   input  logic             bout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [VEC_W-1:0] fail_vec
);

   state_t           state_q, state_d;
   logic [VEC_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [VEC_W-1:0] fail_q, fail_d;
   logic             pass_q, pass_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             exp_diff, exp_bout;
   logic             mismatch;

   fs_golden_model u_golden (
      .a        (idx_q[2]),
      .b        (idx_q[1]),
      .bin      (idx_q[0]),
      .mode     (1'(MODE)),
      .exp_diff (exp_diff),
      .exp_bout (exp_bout)
   );

   assign mismatch = ({diff, bout} != {exp_diff, exp_bout});

   // State and datapath registers; reset aborts any run in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         fail_q  <= '0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-register values; busy/done are decoded from the next state.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fail_d  = fail_q;
      pass_d  = pass_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               idx_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fail_d  = '0;
               pass_d  = 1'b0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CHECK: begin
            if (mismatch) begin
               err_d = err_q + ERR_W'(1);
               if (err_q == '0) begin
                  fail_d = idx_q;
               end
            end
            if (idx_q == LAST_VEC) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + VEC_W'(1);
               cnt_d   = '0;
               state_d = SETTLE;
            end
         end
         DONE: begin
            pass_d  = (err_q == '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SETTLE) || (state_d == CHECK);
      done_d = (state_d == DONE);
   end

   assign a         = idx_q[2];
   assign b         = idx_q[1];
   assign bin       = idx_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: tb/tb_fs_vector_checker.sv
// Directed bench for fs_vector_checker with a behavioural device under check and a result scoreboard.
module tb_fs_vector_checker;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instances: 0 = S2/sub, 1 = S2/add, 2 = S1/sub, 3 = S15/sub
   logic       start [4];
   logic       a     [4];
   logic       b     [4];
   logic       bin   [4];
   logic       diff  [4];
   logic       bout  [4];
   logic       busy  [4];
   logic       done  [4];
   logic       pass  [4];
   logic [3:0] err   [4];
   logic [2:0] fv    [4];

   // Device kinds: 0 = correct subtractor, 1 = subtractor with bout stuck at 0, 2 = correct adder
   int devkind;
   int tests = 0;
   int fails = 0;
   int done_cnt [4];

   typedef struct {
      logic [3:0] err;
      logic [2:0] fv;
      logic       pass;
   } exp_t;

   exp_t sb[$];

   function automatic logic dev_bout(input int kind, input logic x, input logic y, input logic z);
      case (kind)
         0:       return (!x & y) | (!x & z) | (y & z);
         1:       return 1'b0;
         default: return (x & y) | (x & z) | (y & z);
      endcase
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dev
      assign diff[g] = a[g] ^ b[g] ^ bin[g];
      assign bout[g] = dev_bout(devkind, a[g], b[g], bin[g]);
   end

   fs_vector_checker #(.SETTLE_CYCLES(2),  .MODE(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]), .bin(bin[0]),
      .diff(diff[0]), .bout(bout[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .err_count(err[0]), .fail_vec(fv[0]));
   fs_vector_checker #(.SETTLE_CYCLES(2),  .MODE(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]), .bin(bin[1]),
      .diff(diff[1]), .bout(bout[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .err_count(err[1]), .fail_vec(fv[1]));
   fs_vector_checker #(.SETTLE_CYCLES(1),  .MODE(0)) u_dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .a(a[2]), .b(b[2]), .bin(bin[2]),
      .diff(diff[2]), .bout(bout[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
      .err_count(err[2]), .fail_vec(fv[2]));
   fs_vector_checker #(.SETTLE_CYCLES(15), .MODE(0)) u_dut3 (
      .clk(clk), .rst(rst), .start(start[3]), .a(a[3]), .b(b[3]), .bin(bin[3]),
      .diff(diff[3]), .bout(bout[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
      .err_count(err[3]), .fail_vec(fv[3]));

   // Count done pulses mid-cycle so each one-cycle pulse is seen exactly once.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (done[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
      end
   end

   function automatic int settle_of(input int sel);
      case (sel)
         0, 1:    return 2;
         2:       return 1;
         default: return 15;
      endcase
   endfunction

   // Expected run outcome from arithmetic reference versus the behavioural device.
   function automatic exp_t predict(input int sel, input int kind);
      exp_t       e;
      logic [2:0] vv;
      logic       va, vb, vc, dd, db, rd, rb;
      int         s, d;
      e.err = '0;
      e.fv  = '0;
      for (int v = 0; v < 8; v++) begin
         vv = 3'(v);
         va = vv[2];
         vb = vv[1];
         vc = vv[0];
         dd = va ^ vb ^ vc;
         db = dev_bout(kind, va, vb, vc);
         if (sel == 1) begin
            s  = int'(va) + int'(vb) + int'(vc);
            rd = (s % 2) != 0;
            rb = s >= 2;
         end else begin
            d  = int'(va) - int'(vb) - int'(vc);
            rd = (d % 2) != 0;
            rb = d < 0;
         end
         if ({dd, db} != {rd, rb}) begin
            if (e.err == 4'd0) e.fv = vv;
            e.err = e.err + 4'd1;
         end
      end
      e.pass = (e.err == 4'd0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One full run on instance sel; repulse > 0 re-asserts start for one cycle after that edge.
   task automatic run(input int sel, input int kind, input int repulse);
      int   s;
      int   got;
      int   dc0;
      exp_t e;
      s       = settle_of(sel);
      got     = -1;
      devkind = kind;
      dc0     = done_cnt[sel];
      sb.push_back(predict(sel, kind));
      @(negedge clk) start[sel] = 1'b1;
      @(posedge clk);
      #1 start[sel] = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) begin
            chk("busy_run", 32'(busy[sel]), 32'd1);
            chk("vec0", 32'({a[sel], b[sel], bin[sel]}), 32'd0);
            chk("pass_clr", 32'(pass[sel]), 32'd0);
         end
         if (k == s + 1) chk("vec1", 32'({a[sel], b[sel], bin[sel]}), 32'd1);
         if (k == repulse) start[sel] = 1'b1;
         if (k == repulse + 1) start[sel] = 1'b0;
         if (done[sel] === 1'b1) begin
            got = k;
            break;
         end
      end
      start[sel] = 1'b0;
      chk("done_edge", 32'(got), 32'(8 * (s + 1)));
      e = sb.pop_front();
      chk("err_count", 32'(err[sel]), 32'(e.err));
      chk("fail_vec", 32'(fv[sel]), 32'(e.fv));
      @(posedge clk);
      #1;
      chk("pass", 32'(pass[sel]), 32'(e.pass));
      chk("done_width", 32'(done[sel]), 32'd0);
      chk("busy_idle", 32'(busy[sel]), 32'd0);
      chk("done_pulses", 32'(done_cnt[sel] - dc0), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      rst     = 1'b1;
      devkind = 0;
      for (int i = 0; i < 4; i++) begin
         start[i]    = 1'b0;
         done_cnt[i] = 0;
      end
      #12;
      for (int i = 0; i < 4; i++) begin
         chk("rst_vec",  32'({a[i], b[i], bin[i]}), 32'd0);
         chk("rst_busy", 32'(busy[i]), 32'd0);
         chk("rst_done", 32'(done[i]), 32'd0);
         chk("rst_pass", 32'(pass[i]), 32'd0);
         chk("rst_err",  32'(err[i]), 32'd0);
         chk("rst_fv",   32'(fv[i]), 32'd0);
      end
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);

      run(0, 0, -1);   // correct subtractor
      run(0, 1, -1);   // bout stuck at 0
      repeat (5) @(negedge clk);
      chk("err_hold",  32'(err[0]), 32'd4);
      chk("fv_hold",   32'(fv[0]), 32'd1);
      chk("pass_hold", 32'(pass[0]), 32'd0);
      run(1, 2, -1);   // correct adder, adder model
      run(0, 2, -1);   // adder checked against subtractor model
      run(0, 0, 9);    // start re-pulsed during SETTLE of vector 3

      // Reset while idx=5 aborts the run
      devkind = 1;
      dc      = done_cnt[0];
      @(negedge clk) start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      chk("abort_idx5", 32'({a[0], b[0], bin[0]}), 32'd5);
      chk("abort_err",  32'(err[0]), 32'd3);
      chk("abort_busy", 32'(busy[0]), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_vec",  32'({a[0], b[0], bin[0]}), 32'd0);
      chk("abort_busy0", 32'(busy[0]), 32'd0);
      chk("abort_err0", 32'(err[0]), 32'd0);
      chk("abort_fv0",  32'(fv[0]), 32'd0);
      chk("abort_pass", 32'(pass[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("abort_nodone", 32'(done_cnt[0] - dc), 32'd0);
      chk("abort_idle",   32'(busy[0]), 32'd0);
      run(0, 0, -1);   // clean run after abort

      run(2, 0, -1);   // SETTLE_CYCLES = 1
      run(3, 0, -1);   // SETTLE_CYCLES = 15

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
